// File: rtl/morse_encode_transmit.sv
// Morse keyer: latches a packed word of character codes and keys it out on `signal`
// using dit/dah/word durations counted in `ce` ticks.
module morse_encode_transmit #(
  parameter int unsigned CHAR_W      = 6,
  parameter int unsigned MAX_CHARS   = 6,
  parameter int unsigned PULSE_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic                          ce,
  input  logic [PULSE_CNT_W-1:0]        dit_time,
  input  logic [PULSE_CNT_W-1:0]        dah_time,
  input  logic [PULSE_CNT_W-1:0]        word_time,
  input  logic                          start,
  input  logic [CHAR_W*MAX_CHARS-1:0]   word,
  output logic                          signal,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int unsigned SlotW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int unsigned WordW = CHAR_W * MAX_CHARS;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMark,
    StGap,
    StWordGap,
    StDone
  } state_e;

  state_e                 state_q;
  logic [WordW-1:0]       word_q;
  logic [SlotW-1:0]       slot_q;
  logic [4:0]             pat_q;   // remaining elements, current one at bit 4
  logic [2:0]             rem_q;   // elements left including current; 0 = inter-char gap
  logic [PULSE_CNT_W-1:0] cnt_q;

  // {length[2:0], pattern[4:0]}; pattern right-aligned, 1 = dah, MSB-first
  function automatic logic [7:0] rom(input logic [CHAR_W-1:0] code);
    logic [7:0] r;
    case (32'(code))
      1:  r = {3'd2, 5'b00001};  // A
      2:  r = {3'd4, 5'b01000};  // B
      3:  r = {3'd4, 5'b01010};  // C
      4:  r = {3'd3, 5'b00100};  // D
      5:  r = {3'd1, 5'b00000};  // E
      6:  r = {3'd4, 5'b00010};  // F
      7:  r = {3'd3, 5'b00110};  // G
      8:  r = {3'd4, 5'b00000};  // H
      9:  r = {3'd2, 5'b00000};  // I
      10: r = {3'd4, 5'b00111};  // J
      11: r = {3'd3, 5'b00101};  // K
      12: r = {3'd4, 5'b00100};  // L
      13: r = {3'd2, 5'b00011};  // M
      14: r = {3'd2, 5'b00010};  // N
      15: r = {3'd3, 5'b00111};  // O
      16: r = {3'd4, 5'b00110};  // P
      17: r = {3'd4, 5'b01101};  // Q
      18: r = {3'd3, 5'b00010};  // R
      19: r = {3'd3, 5'b00000};  // S
      20: r = {3'd1, 5'b00001};  // T
      21: r = {3'd3, 5'b00001};  // U
      22: r = {3'd4, 5'b00001};  // V
      23: r = {3'd3, 5'b00011};  // W
      24: r = {3'd4, 5'b01001};  // X
      25: r = {3'd4, 5'b01011};  // Y
      26: r = {3'd4, 5'b01100};  // Z
      27: r = {3'd5, 5'b11111};  // 0
      28: r = {3'd5, 5'b01111};  // 1
      29: r = {3'd5, 5'b00111};  // 2
      30: r = {3'd5, 5'b00011};  // 3
      31: r = {3'd5, 5'b00001};  // 4
      32: r = {3'd5, 5'b00000};  // 5
      33: r = {3'd5, 5'b10000};  // 6
      34: r = {3'd5, 5'b11000};  // 7
      35: r = {3'd5, 5'b11100};  // 8
      36: r = {3'd5, 5'b11110};  // 9
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  function automatic logic is_valid(input logic [CHAR_W-1:0] code);
    return (32'(code) >= 1) && (32'(code) <= 36);
  endfunction

  function automatic logic [PULSE_CNT_W-1:0] dur(input logic [PULSE_CNT_W-1:0] d);
    return (d == '0) ? PULSE_CNT_W'(1) : d;
  endfunction

  // Highest non-empty slot at or below slot_q, and whether any valid code lies below slot_q.
  logic              found;
  logic [SlotW-1:0]  found_idx;
  logic [CHAR_W-1:0] found_code;
  logic [CHAR_W-1:0] code_i;
  logic              later_valid;
  logic [7:0]        rom_w;
  logic [2:0]        load_len;
  logic [4:0]        load_pat;

  always_comb begin
    found       = 1'b0;
    found_idx   = '0;
    found_code  = '0;
    code_i      = '0;
    later_valid = 1'b0;
    for (int i = 0; i < int'(MAX_CHARS); i++) begin
      code_i = word_q[i*CHAR_W +: CHAR_W];
      if ((code_i != '0) && (i <= int'(slot_q))) begin
        found      = 1'b1;
        found_idx  = SlotW'(i);
        found_code = code_i;
      end
      if (is_valid(code_i) && (i < int'(slot_q))) later_valid = 1'b1;
    end
    rom_w    = rom(found_code);
    load_len = rom_w[7:5];
    load_pat = rom_w[4:0] << (3'd5 - load_len);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= StIdle;
      word_q  <= '0;
      slot_q  <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      signal  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            word_q  <= word;
            slot_q  <= SlotW'(MAX_CHARS - 1);
            error   <= 1'b0;
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (!found) begin
            cnt_q   <= dur(word_time);
            state_q <= StWordGap;
          end else if (is_valid(found_code)) begin
            slot_q  <= found_idx;
            pat_q   <= load_pat;
            rem_q   <= load_len;
            cnt_q   <= load_pat[4] ? dur(dah_time) : dur(dit_time);
            signal  <= 1'b1;
            state_q <= StMark;
          end else begin
            // Invalid code: skip it, one LOAD cycle per invalid slot
            error <= 1'b1;
            if (found_idx == '0) begin
              cnt_q   <= dur(word_time);
              state_q <= StWordGap;
            end else begin
              slot_q <= found_idx - SlotW'(1);
            end
          end
        end
        StMark: begin
          if (ce) begin
            if (cnt_q == PULSE_CNT_W'(1)) begin
              signal <= 1'b0;
              if (rem_q > 3'd1) begin
                pat_q   <= pat_q << 1;
                rem_q   <= rem_q - 3'd1;
                cnt_q   <= dur(dit_time);
                state_q <= StGap;
              end else if (later_valid) begin
                rem_q   <= 3'd0;
                cnt_q   <= dur(dah_time);
                state_q <= StGap;
              end else begin
                cnt_q   <= dur(word_time);
                state_q <= StWordGap;
              end
            end else begin
              cnt_q <= cnt_q - PULSE_CNT_W'(1);
            end
          end
        end
        StGap: begin
          if (ce) begin
            if (cnt_q == PULSE_CNT_W'(1)) begin
              if (rem_q == 3'd0) begin
                slot_q  <= slot_q - SlotW'(1);
                state_q <= StLoad;
              end else begin
                cnt_q   <= pat_q[4] ? dur(dah_time) : dur(dit_time);
                signal  <= 1'b1;
                state_q <= StMark;
              end
            end else begin
              cnt_q <= cnt_q - PULSE_CNT_W'(1);
            end
          end
        end
        StWordGap: begin
          if (ce) begin
            if (cnt_q == PULSE_CNT_W'(1)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q - PULSE_CNT_W'(1);
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_encode_transmit.sv
// Directed bench for morse_encode_transmit: per-cycle checks of signal/busy/done/error
// against hand-derived mark windows.
module tb_morse_encode_transmit;

  logic        clk = 1'b0;
  logic        sclr;
  logic        ce;
  logic        start;
  logic [15:0] dit_time;
  logic [15:0] dah_time;
  logic [15:0] word_time;
  logic [35:0] word;
  logic        signal;
  logic        busy;
  logic        done;
  logic        error;

  int compared   = 0;
  int mismatched = 0;
  logic exp_sig [0:63];

  always #5 clk = ~clk;

  morse_encode_transmit #(
    .CHAR_W     (6),
    .MAX_CHARS  (6),
    .PULSE_CNT_W(16)
  ) dut (
    .clk      (clk),
    .sclr     (sclr),
    .ce       (ce),
    .dit_time (dit_time),
    .dah_time (dah_time),
    .word_time(word_time),
    .start    (start),
    .word     (word),
    .signal   (signal),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic clear_marks();
    for (int i = 0; i < 64; i++) exp_sig[i] = 1'b0;
  endtask

  task automatic add_mark(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_sig[i] = 1'b1;
  endtask

  // Start at cycle 0, then check cycles 1..n. done_c = 0 means no done expected;
  // err_from = 0 means error stays low. start_c/sclr_c pulse those inputs in that cycle.
  task automatic run(input string name, input logic [35:0] w, input int n,
                     input int busy_hi, input int done_c, input int err_from,
                     input int div, input int start_c, input int sclr_c);
    @(negedge clk);
    word  = w;
    start = 1'b1;
    sclr  = 1'b0;
    ce    = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk($sformatf("%s signal@%0d", name, c), signal, exp_sig[c]);
      chk($sformatf("%s busy@%0d", name, c), busy, (c <= busy_hi));
      chk($sformatf("%s done@%0d", name, c), done, (c == done_c));
      chk($sformatf("%s error@%0d", name, c), error, (err_from > 0) && (c >= err_from));
      start = (c == start_c);
      sclr  = (c == sclr_c);
      ce    = ((c % div) == 0);
      if (c == 1) word = {6{6'd20}};  // later word changes must be ignored
    end
  endtask

  initial begin
    sclr      = 1'b1;
    ce        = 1'b1;
    start     = 1'b0;
    word      = '0;
    dit_time  = 16'd2;
    dah_time  = 16'd6;
    word_time = 16'd14;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset signal", signal, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset error", error, 1'b0);
    sclr = 1'b0;

    // start coincident with sclr is ignored
    @(negedge clk);
    word  = {30'd0, 6'd5};
    start = 1'b1;
    sclr  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sclr  = 1'b0;
    @(negedge clk);
    chk("start+sclr busy", busy, 1'b0);
    chk("start+sclr signal", signal, 1'b0);

    // "E"
    clear_marks();
    add_mark(2, 3);
    run("E", {30'd0, 6'd5}, 20, 17, 18, 0, 1, 0, 0);

    // "A"
    clear_marks();
    add_mark(2, 3);
    add_mark(6, 11);
    run("A", {30'd0, 6'd1}, 28, 25, 26, 0, 1, 0, 0);

    // "ET" in slots 1,0
    clear_marks();
    add_mark(2, 3);
    add_mark(11, 16);
    run("ET", {24'd0, 6'd5, 6'd20}, 33, 30, 31, 0, 1, 0, 0);

    // Invalid slot 5, "E" in slot 0: one extra LOAD cycle, error sticky
    clear_marks();
    add_mark(3, 4);
    run("INV", {6'd40, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5}, 22, 18, 19, 2, 1, 0, 0);

    // Digit "0" (-----), dit=0 treated as 1; error cleared by this start
    dit_time  = 16'd0;
    dah_time  = 16'd3;
    word_time = 16'd2;
    clear_marks();
    add_mark(2, 4);
    add_mark(6, 8);
    add_mark(10, 12);
    add_mark(14, 16);
    add_mark(18, 20);
    run("D0", {30'd0, 6'd27}, 25, 22, 23, 0, 1, 0, 0);

    // ce every 4th clk: mark spans 2 ce pulses; start mid-mark ignored
    dit_time  = 16'd2;
    dah_time  = 16'd6;
    word_time = 16'd3;
    clear_marks();
    add_mark(2, 8);
    run("CE4", {30'd0, 6'd5}, 24, 20, 21, 0, 4, 5, 0);

    // Same, with sclr in the word gap: abort with no done
    run("ABORT", {30'd0, 6'd5}, 24, 12, 0, 0, 4, 0, 12);

    // All slots empty: one LOAD, word gap, done
    word_time = 16'd14;
    clear_marks();
    run("EMPTY", 36'd0, 18, 15, 16, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
